// File: rtl/bcd_pkg.sv
// Shared constants for the BCD scan display: digit geometry and active-low
// seven-segment patterns ordered {g,f,e,d,c,b,a}.
package bcd_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/bcd_scan_display_if.sv
// Display-side bundle: BCD digits and blanking control in, multiplexed
// segment/anode drive and frame pulse out.
interface bcd_scan_display_if;
  import bcd_pkg::*;

  logic [NUM_DIGITS*DIGIT_W-1:0] digits;
  logic                          blank_lz;
  logic [6:0]                    seg;
  logic [NUM_DIGITS-1:0]         an;
  logic                          frame_tick;

  modport master (output digits, blank_lz, input seg, an, frame_tick);
  modport slave  (input digits, blank_lz, output seg, an, frame_tick);

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD code to active-low seven-segment pattern; codes 10..15
// render as a dash so bad upstream data is visible on the display.
module bcd_to_7seg
  import bcd_pkg::*;
(
  input  digit_t     code,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    case (code)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed common-anode driver: prescaled digit scan, once-per-frame
// shadow capture of the BCD inputs, leading-zero blanking and registered drive.
module bcd_scan_display
  import bcd_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic                clock,
  input  logic                reset,
  bcd_scan_display_if.slave   bus
);

  localparam int              CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [1:0]      IDX_LAST = 2'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]              cnt_reg;
  logic [1:0]                    idx_reg;
  logic [NUM_DIGITS*DIGIT_W-1:0] shadow_reg;
  logic [6:0]                    seg_reg;
  logic [NUM_DIGITS-1:0]         an_reg;
  logic                          frame_tick_reg;

  digit_t                  shadow_digit [NUM_DIGITS];
  logic [NUM_DIGITS:1]     upper_zero;
  logic [NUM_DIGITS-1:0]   blank_mask;
  digit_t                  cur_code;
  logic [6:0]              cur_pattern;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;
  logic                    tick;
  logic                    capture;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_split
      assign shadow_digit[gi] = shadow_reg[gi*DIGIT_W +: DIGIT_W];
    end

    // upper_zero[k] is set when digits k..top are all zero; an invalid code is non-zero.
    assign upper_zero[NUM_DIGITS] = 1'b1;
    assign blank_mask[0]          = 1'b0;
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
      assign upper_zero[gi] = (shadow_digit[gi] == '0) && upper_zero[gi+1];
      assign blank_mask[gi] = bus.blank_lz && upper_zero[gi];
    end
  endgenerate

  assign cur_code = shadow_digit[idx_reg];

  bcd_to_7seg u_dec (
    .code    (cur_code),
    .pattern (cur_pattern)
  );

  assign tick     = (cnt_reg == CNT_MAX);
  assign capture  = tick && (idx_reg == IDX_LAST);
  assign seg_next = blank_mask[idx_reg] ? SEG_BLANK : cur_pattern;
  assign an_next  = ~(4'b0001 << idx_reg);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shadow_reg     <= '0;
      seg_reg        <= SEG_BLANK;
      an_reg         <= '1;
      frame_tick_reg <= 1'b0;
    end else begin
      cnt_reg        <= tick ? '0 : cnt_reg + CNT_W'(1);
      if (tick) begin
        idx_reg <= idx_reg + 2'd1;
      end
      // Shadow only moves at the frame boundary so a frame never mixes two input values.
      if (capture) begin
        shadow_reg <= bus.digits;
      end
      frame_tick_reg <= capture;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.an         = an_reg;
  assign bus.frame_tick = frame_tick_reg;

endmodule
